lsu_mem_initiator: RTL

- Load/store initiator that sits between the execute stage and the word-organised data memory. It drives the memory-request side of the data memory interface.
- Accepts one load/store request at a time over a valid/ready handshake. Issues word-aligned, byte-enabled memory accesses to the memory, then returns the load result with extraction and sign/zero extension applied.
- Misaligned half/word accesses are split into two consecutive word accesses and merged, so the core never sees a misalignment.

---
 rtl/lsu_mem_initiator_if.sv | 31 +++
 rtl/lsu_mem_initiator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator_if.sv
// rtl/lsu_mem_initiator_if.sv - request/response and data-memory bus for lsu_mem_initiator
// master is the initiator's view; slave is the core plus memory side.
interface lsu_mem_initiator_if #(
  parameter int WIDTH = 32
);
  logic             ReqValid;
  logic             ReqReady;
  logic             ReqWrite;
  logic [1:0]       LoadSrc;
  logic             LoadSign;
  logic [WIDTH-1:0] Addr;
  logic [WIDTH-1:0] WriteData;
  logic             RespValid;
  logic [WIDTH-1:0] ReadData;
  logic             MemEn;
  logic             MemWrite;
  logic [WIDTH-1:0] MemAddr;
  logic [3:0]       MemByteEn;
  logic [WIDTH-1:0] MemWData;
  logic [WIDTH-1:0] MemRData;

  modport master (
    input  ReqValid, ReqWrite, LoadSrc, LoadSign, Addr, WriteData, MemRData,
    output ReqReady, RespValid, ReadData, MemEn, MemWrite, MemAddr, MemByteEn, MemWData
  );

  modport slave (
    output ReqValid, ReqWrite, LoadSrc, LoadSign, Addr, WriteData, MemRData,
    input  ReqReady, RespValid, ReadData, MemEn, MemWrite, MemAddr, MemByteEn, MemWData
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - load/store initiator driving a word-organised data memory
// Misaligned half/word accesses become two word accesses whose read data is merged.
module lsu_mem_initiator #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsu_mem_initiator_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_LAST,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_write;
  logic [1:0]       r_src;
  logic             r_sign;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_word0;
  // Only the low three bytes of the second word can ever reach the result.
  logic [23:0]      r_word1;

  logic [1:0]       w_off;
  logic [2:0]       w_nbytes;
  logic [3:0]       w_nmask;
  logic             w_split;
  logic [7:0]       w_be_span;
  logic [2*WIDTH-1:0] w_wd_span;
  logic [WIDTH-1:0] w_word_addr;
  logic [WIDTH-1:0] w_rd_low;
  logic [WIDTH-1:0] w_load_val;

  assign w_off       = r_addr[1:0];
  assign w_word_addr = {r_addr[WIDTH-1:2], 2'b00};

  always_comb begin
    w_nbytes = 3'd4;
    w_nmask  = 4'b1111;
    case (r_src)
      2'b01: begin
        w_nbytes = 3'd2;
        w_nmask  = 4'b0011;
      end
      2'b10: begin
        w_nbytes = 3'd1;
        w_nmask  = 4'b0001;
      end
      default: begin
        w_nbytes = 3'd4;
        w_nmask  = 4'b1111;
      end
    endcase
  end

  assign w_split = (({1'b0, w_off} + w_nbytes) > 3'd4);

  // Low nibble holds first-word lanes, high nibble the spill into the next word.
  assign w_be_span = {4'b0000, w_nmask} << w_off;
  assign w_wd_span = {{WIDTH{1'b0}}, r_wdata} << {w_off, 3'b000};

  always_comb begin
    w_rd_low = r_word0;
    case (w_off)
      2'd1:    w_rd_low = {r_word1[7:0],  r_word0[31:8]};
      2'd2:    w_rd_low = {r_word1[15:0], r_word0[31:16]};
      2'd3:    w_rd_low = {r_word1[23:0], r_word0[31:24]};
      default: w_rd_low = r_word0;
    endcase
  end

  always_comb begin
    w_load_val = w_rd_low;
    case (r_src)
      2'b01:   w_load_val = {{(WIDTH-16){r_sign & w_rd_low[15]}}, w_rd_low[15:0]};
      2'b10:   w_load_val = {{(WIDTH-8){r_sign & w_rd_low[7]}}, w_rd_low[7:0]};
      default: w_load_val = w_rd_low;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.ReqValid) w_state_nxt = S_ACC0;
      S_ACC0:  w_state_nxt = w_split ? S_ACC1 : S_LAST;
      S_ACC1:  w_state_nxt = S_LAST;
      S_LAST:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ReqReady  = 1'b0;
    bus.RespValid = 1'b0;
    bus.ReadData  = '0;
    bus.MemEn     = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.MemAddr   = '0;
    bus.MemByteEn = 4'b0000;
    bus.MemWData  = '0;
    case (r_state)
      S_IDLE: bus.ReqReady = 1'b1;
      S_ACC0: begin
        bus.MemEn     = 1'b1;
        bus.MemWrite  = r_write;
        bus.MemAddr   = w_word_addr;
        bus.MemByteEn = w_be_span[3:0];
        bus.MemWData  = w_wd_span[WIDTH-1:0];
      end
      S_ACC1: begin
        bus.MemEn     = 1'b1;
        bus.MemWrite  = r_write;
        bus.MemAddr   = w_word_addr + WIDTH'(4);
        bus.MemByteEn = w_be_span[7:4];
        bus.MemWData  = w_wd_span[2*WIDTH-1:WIDTH];
      end
      S_RESP: begin
        bus.RespValid = 1'b1;
        bus.ReadData  = r_write ? '0 : w_load_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_src   <= 2'b00;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word0 <= '0;
      r_word1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.ReqValid) begin
            r_write <= bus.ReqWrite;
            r_src   <= bus.LoadSrc;
            r_sign  <= bus.LoadSign;
            r_addr  <= bus.Addr;
            r_wdata <= bus.WriteData;
            r_word0 <= '0;
            r_word1 <= '0;
          end
        end
        // Read data lags MemEn by one cycle, so ACC1 sees the first word.
        S_ACC1: r_word0 <= bus.MemRData;
        S_LAST: begin
          if (w_split) r_word1 <= bus.MemRData[23:0];
          else         r_word0 <= bus.MemRData;
        end
        default: ;
      endcase
    end
  end

endmodule
